// File: rtl/sr_pkg.sv
//------------------------------------------------------------------------------
// Module  : sr_pkg
// Purpose : Shared FSM encoding and conflict-policy constants for sr_drive_ctrl.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      GAP     = 2'd3
   } state_t;

   localparam int POL_DROP = 0;
   localparam int POL_RST  = 1;
   localparam int POL_SET  = 2;

endpackage

`default_nettype wire

// File: rtl/sr_debounce.sv
//------------------------------------------------------------------------------
// Module  : sr_debounce
// Purpose : Two-flop synchroniser, debounce counter and rising-edge strobe.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sr_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_rise
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_level;
   logic       r_level_d;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= 8'd0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         // Any sample agreeing with the current level restarts the stability run
         if (r_sync2 == r_level) begin
            r_cnt <= 8'd0;
         end else if (w_cnt_inc == 8'(DB_CYCLES)) begin
            r_level <= ~r_level;
            r_cnt   <= 8'd0;
         end else begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign o_rise = r_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/sr_drive_ctrl.sv
//------------------------------------------------------------------------------
// Module  : sr_drive_ctrl
// Purpose : Debounced, arbitrated, fixed-width s/r pulse driver for an SR flop.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sr_drive_ctrl
   import sr_pkg::*;
#(
   parameter int DB_CYCLES       = 4,
   parameter int PULSE_CYCLES    = 2,
   parameter int GAP_CYCLES      = 1,
   parameter int CONFLICT_POLICY = 0,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_btn,
   input  logic             rst_btn,
   output logic             s,
   output logic             r,
   output logic             busy,
   output logic             conflict,
   output logic [CNT_W-1:0] pulse_cnt
);

   localparam logic [3:0] c_PULSE_LAST = 4'(PULSE_CYCLES - 1);
   localparam logic [3:0] c_GAP_LAST   = 4'(GAP_CYCLES - 1);

   logic             w_rise_s;
   logic             w_rise_r;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_tmr;
   logic [3:0]       w_tmr_nxt;
   logic             r_pend_s;
   logic             r_pend_r;
   logic             w_pend_s_nxt;
   logic             w_pend_r_nxt;
   logic             w_req_s;
   logic             w_req_r;
   logic             w_conflict_nxt;
   logic             w_issue;
   logic             r_s;
   logic             r_r;
   logic             r_conflict;
   logic [CNT_W-1:0] r_pulse_cnt;

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (set_btn),
      .o_rise (w_rise_s)
   );

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (rst_btn),
      .o_rise (w_rise_r)
   );

   assign w_req_s = r_pend_s | w_rise_s;
   assign w_req_r = r_pend_r | w_rise_r;

   always_comb begin
      w_state_nxt    = r_state;
      w_tmr_nxt      = r_tmr;
      w_pend_s_nxt   = w_req_s;
      w_pend_r_nxt   = w_req_r;
      w_conflict_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            w_tmr_nxt    = 4'd0;
            // Every request visible in IDLE is either issued or discarded now
            w_pend_s_nxt = 1'b0;
            w_pend_r_nxt = 1'b0;
            if (w_req_s && w_req_r) begin
               if (CONFLICT_POLICY == POL_RST) begin
                  w_state_nxt = PULSE_R;
               end else if (CONFLICT_POLICY == POL_SET) begin
                  w_state_nxt = PULSE_S;
               end else begin
                  w_conflict_nxt = 1'b1;
               end
            end else if (w_req_s) begin
               w_state_nxt = PULSE_S;
            end else if (w_req_r) begin
               w_state_nxt = PULSE_R;
            end
         end
         PULSE_S, PULSE_R: begin
            if (r_tmr == c_PULSE_LAST) begin
               w_state_nxt = GAP;
               w_tmr_nxt   = 4'd0;
            end else begin
               w_tmr_nxt = r_tmr + 4'd1;
            end
         end
         GAP: begin
            if (r_tmr == c_GAP_LAST) begin
               w_state_nxt = IDLE;
               w_tmr_nxt   = 4'd0;
            end else begin
               w_tmr_nxt = r_tmr + 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tmr_nxt   = 4'd0;
         end
      endcase
   end

   assign w_issue = (r_state == IDLE) && (w_state_nxt != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_tmr       <= 4'd0;
         r_pend_s    <= 1'b0;
         r_pend_r    <= 1'b0;
         r_s         <= 1'b0;
         r_r         <= 1'b0;
         r_conflict  <= 1'b0;
         r_pulse_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tmr      <= w_tmr_nxt;
         r_pend_s   <= w_pend_s_nxt;
         r_pend_r   <= w_pend_r_nxt;
         // Dedicated output flops keep s/r glitch-free across state changes
         r_s        <= (w_state_nxt == PULSE_S);
         r_r        <= (w_state_nxt == PULSE_R);
         r_conflict <= w_conflict_nxt;
         if (w_issue) begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
         end
      end
   end

   assign s         = r_s;
   assign r         = r_r;
   assign busy      = (r_state != IDLE);
   assign conflict  = r_conflict;
   assign pulse_cnt = r_pulse_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_sr_drive_ctrl
// Purpose : Self-checking bench for sr_drive_ctrl, one DUT per conflict policy.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sr_drive_ctrl;

   localparam int DB = 4;
   localparam int PW = 2;
   localparam int GW = 1;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic       set_btn = 1'b0;
   logic       rst_btn = 1'b0;
   logic       s_o    [3];
   logic       r_o    [3];
   logic       busy_o [3];
   logic       conf_o [3];
   logic [7:0] cnt_o  [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar p = 0; p < 3; p++) begin : g_dut
      sr_drive_ctrl #(
         .DB_CYCLES       (DB),
         .PULSE_CYCLES    (PW),
         .GAP_CYCLES      (GW),
         .CONFLICT_POLICY (p),
         .CNT_W           (8)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .set_btn   (set_btn),
         .rst_btn   (rst_btn),
         .s         (s_o[p]),
         .r         (r_o[p]),
         .busy      (busy_o[p]),
         .conflict  (conf_o[p]),
         .pulse_cnt (cnt_o[p])
      );
   end

   task automatic check(input string nm, input int idx, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Debounce: a level flips once the last DB synced samples all disagree with it.
   // Scheduler: an issued command occupies PW+GW busy cycles, output high for the first PW.
   bit m_s1 [2];
   bit m_s2 [2];
   bit m_lvl[2];
   bit m_stb[2];
   bit hist0[$];
   bit hist1[$];
   int m_rem  [3];
   int m_kind [3];
   bit m_pend_s[3];
   bit m_pend_r[3];
   bit m_conf [3];
   int m_cnt  [3];

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_stb[c] = 0;
      end
      hist0.delete();
      hist1.delete();
      for (int p = 0; p < 3; p++) begin
         m_rem[p] = 0; m_kind[p] = 0; m_pend_s[p] = 0; m_pend_r[p] = 0;
         m_conf[p] = 0; m_cnt[p] = 0;
      end
   endtask

   task automatic issue(input int p, input int kind);
      m_rem[p]  = PW + GW;
      m_kind[p] = kind;
      m_cnt[p]  = (m_cnt[p] + 1) % 256;
   endtask

   task automatic sched_step(input int p, input bit a_in, input bit b_in);
      bit a, b;
      m_conf[p] = 0;
      if (m_rem[p] > 0) begin
         m_rem[p]--;
         m_pend_s[p] |= a_in;
         m_pend_r[p] |= b_in;
      end else begin
         a = a_in | m_pend_s[p];
         b = b_in | m_pend_r[p];
         m_pend_s[p] = 0;
         m_pend_r[p] = 0;
         if (a && b) begin
            if (p == 0) m_conf[p] = 1;
            else if (p == 1) issue(p, 2);
            else issue(p, 1);
         end else if (a) issue(p, 1);
         else if (b) issue(p, 2);
      end
   endtask

   function automatic bit all_differ(input bit q[$], input bit lvl);
      if (q.size() < DB) return 0;
      for (int i = 0; i < DB; i++)
         if (q[q.size() - 1 - i] == lvl) return 0;
      return 1;
   endfunction

   task automatic model_step();
      bit flip;
      for (int p = 0; p < 3; p++) sched_step(p, m_stb[0], m_stb[1]);
      hist0.push_back(m_s2[0]);
      hist1.push_back(m_s2[1]);
      if (hist0.size() > DB) void'(hist0.pop_front());
      if (hist1.size() > DB) void'(hist1.pop_front());
      for (int c = 0; c < 2; c++) begin
         flip = (c == 0) ? all_differ(hist0, m_lvl[c]) : all_differ(hist1, m_lvl[c]);
         m_stb[c] = flip && !m_lvl[c];
         if (flip) m_lvl[c] = ~m_lvl[c];
      end
      m_s2[0] = m_s1[0]; m_s1[0] = set_btn;
      m_s2[1] = m_s1[1]; m_s1[1] = rst_btn;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int p = 0; p < 3; p++) begin
            check("s",        p, int'(s_o[p]),    int'(m_kind[p] == 1 && m_rem[p] > GW));
            check("r",        p, int'(r_o[p]),    int'(m_kind[p] == 2 && m_rem[p] > GW));
            check("busy",     p, int'(busy_o[p]), int'(m_rem[p] > 0));
            check("conflict", p, int'(conf_o[p]), int'(m_conf[p]));
            check("pulse_cnt", p, int'(cnt_o[p]), m_cnt[p]);
            check("s_and_r",  p, int'(s_o[p] & r_o[p]), 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic measure_latency(input string nm, output int n);
      @(posedge clk);
      #1;
      n = 0;
      while (!s_o[0] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(nm, 0, n, DB + 2);
   endtask

   initial begin
      int n, sc, bc, rc, ov, cf, base, s_last, r_first, ls, lr;

      #1 rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);

      // clean press: latency, pulse width, busy window
      set_btn = 1'b1;
      measure_latency("lat_clean", n);
      sc = 0; bc = 0;
      repeat (8) begin
         sc += int'(s_o[0]);
         bc += int'(busy_o[0]);
         @(posedge clk);
         #1;
      end
      check("clean_s_width", 0, sc, 2);
      check("clean_busy_width", 0, bc, 3);
      check("clean_cnt", 0, int'(cnt_o[0]), 1);
      cyc(10);
      set_btn = 1'b0;
      cyc(12);

      // bouncing press then stable
      base = int'(cnt_o[0]);
      set_btn = 1'b1; cyc(1);
      set_btn = 1'b0; cyc(1);
      set_btn = 1'b1; cyc(1);
      set_btn = 1'b0; cyc(1);
      set_btn = 1'b1;
      measure_latency("lat_bounce", n);
      cyc(12);
      check("bounce_one_pulse", 0, int'(cnt_o[0]) - base, 1);
      set_btn = 1'b0;
      cyc(12);

      // simultaneous press on all three policies
      base = int'(cnt_o[0]);
      set_btn = 1'b1; rst_btn = 1'b1;
      cf = 0; sc = 0; rc = 0; ov = 0; bc = 0;
      repeat (16) begin
         @(posedge clk);
         #1;
         cf += int'(conf_o[0]);
         ov += int'(s_o[0] | r_o[0]);
         rc += int'(r_o[1]) + 10 * int'(s_o[1]);
         sc += int'(s_o[2]) + 10 * int'(r_o[2]);
      end
      check("conf_drop_pulse", 0, cf, 1);
      check("conf_drop_quiet", 0, ov, 0);
      check("conf_drop_cnt", 0, int'(cnt_o[0]) - base, 0);
      check("conf_rst_wins", 1, rc, 2);
      check("conf_set_wins", 2, sc, 2);
      @(negedge clk);
      set_btn = 1'b0; rst_btn = 1'b0;
      cyc(12);

      // set then reset one cycle later: pending reset issued after gap
      base = int'(cnt_o[0]);
      set_btn = 1'b1; cyc(1);
      rst_btn = 1'b1;
      sc = 0; rc = 0; ov = 0; s_last = -1; r_first = -1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (s_o[0]) begin sc++; s_last = i; end
         if (r_o[0]) begin rc++; if (r_first < 0) r_first = i; end
         ov += int'(s_o[0] & r_o[0]);
      end
      check("seq_s_width", 0, sc, 2);
      check("seq_r_width", 0, rc, 2);
      check("seq_overlap", 0, ov, 0);
      check("seq_spacing", 0, r_first - s_last, 3);
      check("seq_cnt", 0, int'(cnt_o[0]) - base, 2);
      @(negedge clk);
      set_btn = 1'b0; rst_btn = 1'b0;
      cyc(12);

      // asynchronous reset in the middle of a set pulse
      set_btn = 1'b1;
      n = 0;
      while (!s_o[0] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("async_s_reached", 0, int'(s_o[0]), 1);
      #2;
      rst_n = 1'b0;
      set_btn = 1'b0;
      #1;
      check("async_s_low", 0, int'(s_o[0]), 0);
      check("async_busy_low", 0, int'(busy_o[0]), 0);
      check("async_cnt_zero", 0, int'(cnt_o[0]), 0);
      cyc(2);
      rst_n = 1'b1;
      sc = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         sc += int'(s_o[0]);
      end
      check("async_no_resume", 0, sc, 0);
      check("async_cnt_after", 0, int'(cnt_o[0]), 0);

      // counter wrap over 256 sequential set requests
      @(negedge clk);
      for (int k = 0; k < 256; k++) begin
         set_btn = 1'b1; cyc(8);
         set_btn = 1'b0; cyc(8);
         if (k == 254) check("wrap_255", 0, int'(cnt_o[0]), 255);
      end
      cyc(4);
      for (int p = 0; p < 3; p++) begin
         check("wrap_zero", p, int'(cnt_o[p]), 0);
         check("wrap_idle", p, int'(busy_o[p]), 0);
      end

      // randomized bouncing on both buttons
      ls = 0; lr = 0;
      repeat (1500) begin
         @(negedge clk);
         if (ls == 0) begin set_btn = 1'($urandom_range(0, 1)); ls = $urandom_range(1, 10); end
         if (lr == 0) begin rst_btn = 1'($urandom_range(0, 1)); lr = $urandom_range(1, 10); end
         ls--; lr--;
      end
      set_btn = 1'b0; rst_btn = 1'b0;
      cyc(20);
      for (int p = 0; p < 3; p++) check("final_idle", p, int'(busy_o[p]), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Upstream driver for the sr_ff storage stage. It takes two raw, asynchronous push-button inputs (set request, reset request) and produces clean, mutually exclusive s/r pulses of fixed width.
- Each input is synchronised, debounced, edge-detected and arbitrated, so the downstream SR flop never sees s=r=1 and never sees a bouncing input.

Parameters:
- DB_CYCLES, 4: consecutive stable synced cycles required before a debounced level changes (legal range 1..255).
- PULSE_CYCLES, 2: cycles s or r is held high per issued command (legal range 1..15).
- GAP_CYCLES, 1: minimum low cycles between two issued pulses (legal range 1..15).
- CONFLICT_POLICY, 0: 0 = drop both and flag conflict; 1 = reset wins; 2 = set wins.
- CNT_W, 8: width of the issued-pulse counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- set_btn, input, 1: raw set request, asynchronous, may bounce.
- rst_btn, input, 1: raw reset request, asynchronous, may bounce.
- s, output, 1: registered set drive to sr_ff.
- r, output, 1: registered reset drive to sr_ff.
- busy, output, 1: high in PULSE_S, PULSE_R and GAP.
- conflict, output, 1: one-cycle pulse when simultaneous requests are dropped (policy 0 only).
- pulse_cnt, output, CNT_W: count of issued pulses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0) applies immediately and asynchronously:
  - s=0, r=0, busy=0, conflict=0, pulse_cnt=0, FSM=IDLE.
  - Sync flops, debounced levels, debounce counters and pending bits all clear to 0.
  - Reset mid-pulse truncates the pulse at once; nothing resumes after release.
- Synchroniser: two flops per button. Debounce, edge detection and arbitration see only the second-stage value.
- Debounce, per channel:
  - An 8-bit counter increments while the synced value differs from the debounced level. It clears whenever they match.
  - When the counter reaches DB_CYCLES, the debounced level toggles and the counter clears.
  - Glitches shorter than DB_CYCLES synced cycles never change the level.
- Request: a one-cycle strobe on the debounced 0->1 transition only. Releasing a button issues nothing.
- Latency:
  - With a clean input, s (or r) rises exactly DB_CYCLES+2 clock edges after the edge that first samples the button high into sync stage 1.
  - Example: DB_CYCLES=4 gives 6 edges.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP.
  - IDLE with set only (strobe or pending): go to PULSE_S, s=1.
  - IDLE with reset only: go to PULSE_R, r=1.
  - IDLE with both: apply CONFLICT_POLICY.
    - Policy 0: stay in IDLE, pulse conflict for one cycle, clear both pending bits.
    - Policy 1: go to PULSE_R; the set request is discarded.
    - Policy 2: go to PULSE_S; the reset request is discarded.
  - PULSE_S / PULSE_R: hold the output for exactly PULSE_CYCLES cycles, then go to GAP with the output low. pulse_cnt increments on entry to PULSE_*.
  - GAP: stay for exactly GAP_CYCLES cycles, then return to IDLE. Pending requests are evaluated in IDLE on the following edge.
- Pending:
  - A strobe arriving while busy sets that channel's one-deep pending bit.
  - Repeat strobes merge into the same bit.
  - A pending bit clears when its pulse is issued or it is discarded by policy.
- Invariant: s and r are never simultaneously 1 in any cycle.
- Width rules:
  - The pulse and gap counters are 4 bits.
  - pulse_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package sr_pkg holds:
  - the FSM state encoding (IDLE=2'd0, PULSE_S=2'd1, PULSE_R=2'd2, GAP=2'd3);
  - the CONFLICT_POLICY constants (POL_DROP=0, POL_RST=1, POL_SET=2).
- One sub-module, sr_debounce, holds the 2-flop sync, the debounce counter and the rising-edge strobe. It is instantiated twice. The FSM, pending bits and counter live in the top.

Test Plan:
- Clean set_btn held 20 cycles, DB=4, PULSE=2 -> s=1 on edges 6 and 7 after first sample; r stays 0; pulse_cnt=1; busy high 3 cycles.
- set_btn bounce pattern 1,0,1,0 at one-cycle spacing, then stable 1 -> exactly one s pulse; s rises 6 edges after the stable edge is first sampled.
- set_btn and rst_btn rise on the same edge, policy 0 -> conflict high 1 cycle; s=r=0 throughout; pulse_cnt=0. Repeat with policy 1 -> one r pulse only.
- set_btn edge, then rst_btn edge 1 cycle later -> s pulse, GAP of 1 cycle, then r pulse; never s&r; pulse_cnt=2.
- rst_n driven low mid-PULSE_S -> s falls without waiting for a clock edge; after release there is no pulse until a new debounced edge; pulse_cnt=0.
- 256 sequential set requests with CNT_W=8 -> pulse_cnt wraps to 0; busy drops after the last GAP.
